// File: rtl/jtpang_objdma.sv
// jtpang_objdma: copies the 512-byte sprite table from VRAM into a private
// object RAM while holding the Z80 bus, and gives the object scanner a read
// port that the CPU cannot disturb mid-frame.
module jtpang_objdma #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          dma_go,
  input  logic          busak_n,
  output logic          busrq,
  output logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_din,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] scan_addr,
  output logic [DW-1:0] scan_dout
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, FLUSH} state_t;

  state_t          state_q, state_d;
  logic            dma_go_l_q, dma_go_l_d;
  logic            busrq_q, busrq_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pending_q, pending_d;
  logic [AW-1:0]   dma_addr_q, dma_addr_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic            wr_en_q, wr_en_d;
  logic [DW-1:0]   scan_dout_q;
  logic [DW-1:0]   mem [2**AW];

  logic start;
  logic step;
  logic last;

  assign start = dma_go & ~dma_go_l_q;
  assign step  = (state_q == XFER) & ~busak_n;
  assign last  = (dma_addr_q == '1);

  // FSM state register; advances only on cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (cen) begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     if (!busak_n) state_d = XFER;
      XFER:    if (step && last) state_d = FLUSH;
      FLUSH:   state_d = (pending_q || start) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and transfer datapath: next values of every registered output
  always_comb begin
    dma_go_l_d = dma_go;
    busrq_d    = busrq_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dma_addr_d = dma_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_en_d    = 1'b0;
    // A start seen while a transfer is in flight is remembered, not lost;
    // any number of such starts collapse into one pending transfer.
    pending_d  = pending_q | (start & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (start) begin
          busrq_d    = 1'b1;
          busy_d     = 1'b1;
          dma_addr_d = '0;
        end
      end
      XFER: begin
        // A stalled step neither advances the address nor queues a write,
        // so the byte is fetched again when the bus comes back.
        if (step) begin
          dma_addr_d = dma_addr_q + 1'b1;
          wr_addr_d  = dma_addr_q;
          wr_en_d    = 1'b1;
        end
      end
      FLUSH: begin
        done_d = 1'b1;
        if (pending_q || start) begin
          // Chain straight into the next request, bus request held high.
          pending_d  = 1'b0;
          dma_addr_d = '0;
        end else begin
          busrq_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, advanced on cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_go_l_q <= 1'b0;
      busrq_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pending_q  <= 1'b0;
      dma_addr_q <= '0;
      wr_addr_q  <= '0;
      wr_en_q    <= 1'b0;
    end else if (cen) begin
      dma_go_l_q <= dma_go_l_d;
      busrq_q    <= busrq_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pending_q  <= pending_d;
      dma_addr_q <= dma_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_en_q    <= wr_en_d;
    end
  end

  // Object RAM write port: VRAM data arrives one cen after its address
  always_ff @(posedge clk) begin
    if (cen && wr_en_q) begin
      mem[wr_addr_q] <= dma_din;
    end
  end

  // Scanner read port: every clk, old data on a same-address write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_dout_q <= '0;
    end else begin
      scan_dout_q <= mem[scan_addr];
    end
  end

  assign busrq     = busrq_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dma_addr  = dma_addr_q;
  assign scan_dout = scan_dout_q;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Directed bench for jtpang_objdma: VRAM and Z80 bus-acknowledge models,
// hand-computed expectations checked with immediate assertions.
module tb_jtpang_objdma;

  localparam int AW   = 9;
  localparam int DW   = 8;
  localparam int WAIT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cen = 1'b0;
  logic          dma_go;
  logic          busak_n;
  logic          busrq;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_din = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] scan_addr;
  logic [DW-1:0] scan_dout;

  logic [7:0] key;
  logic       stall;
  logic       ack_r = 1'b1;
  int         ack_cnt = 0;

  int checks = 0;
  int passes = 0;
  int rq_cnt = 0;
  int done_cnt = 0;
  int fall_cnt = 0;
  logic busrq_prev = 1'b0;

  jtpang_objdma #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .dma_go    (dma_go),
    .busak_n   (busak_n),
    .busrq     (busrq),
    .dma_addr  (dma_addr),
    .dma_din   (dma_din),
    .busy      (busy),
    .done      (done),
    .scan_addr (scan_addr),
    .scan_dout (scan_dout)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cen <= ~cen;

  // VRAM: registered read, data valid one cen after the address
  always @(posedge clk) if (cen) dma_din <= dma_addr[7:0] ^ key;

  // Z80: acknowledges WAIT cens after seeing the request
  always @(posedge clk) begin
    if (cen) begin
      if (!busrq) begin
        ack_cnt <= 0;
        ack_r   <= 1'b1;
      end else begin
        ack_cnt <= ack_cnt + 1;
        if (ack_cnt + 1 >= WAIT) ack_r <= 1'b0;
      end
    end
  end
  assign busak_n = ack_r | stall;

  // Activity monitor, per cen period
  always @(posedge clk) begin
    if (cen && rst_n) begin
      if (busrq) rq_cnt++;
      if (done) done_cnt++;
      if (busrq_prev && !busrq) fall_cnt++;
      busrq_prev = busrq;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    do @(posedge clk); while (cen !== 1'b1);
    #1;
  endtask

  task automatic scan_rd(input int unsigned a, output logic [7:0] d);
    scan_addr = a[AW-1:0];
    @(posedge clk);
    #1;
    d = scan_dout;
  endtask

  task automatic pulse_go();
    dma_go = 1'b1;
    step();
    dma_go = 1'b0;
  endtask

  task automatic wait_addr(input string tag, input int unsigned a);
    bit found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      if (busy && dma_addr == a[AW-1:0]) found = 1;
    end
    chk(tag, found, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (!busy) found = 1;
    end
    chk(tag, found, 1);
  endtask

  task automatic clr_mon();
    rq_cnt = 0;
    done_cnt = 0;
    fall_cnt = 0;
  endtask

  function automatic logic [7:0] img(input int unsigned a, input logic [7:0] k);
    return a[7:0] ^ k;
  endfunction

  initial begin
    logic [7:0] d;
    int errs;
    rst_n = 1'b0;
    dma_go = 1'b0;
    scan_addr = '0;
    stall = 1'b0;
    key = 8'h5A;

    // Reset held with cen running
    for (int i = 0; i < 4; i++) begin
      step();
      chk("reset_outs", {busrq, busy, done, dma_addr, scan_dout}, '0);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_outs", {busrq, busy, done, dma_addr}, '0);
    end

    // Basic copy
    clr_mon();
    pulse_go();
    chk("start_busrq", {busrq, busy}, 2'b11);
    wait_idle("basic_end", 2000);
    chk("done_rise", done, 1);
    step();
    chk("done_fall", done, 0);
    step();
    chk("basic_rq_cens", rq_cnt, 3 + 2 + 512);
    chk("basic_done_cnt", done_cnt, 1);
    scan_rd(0, d);   chk("scan_0", d, 8'h5A);
    scan_rd(255, d); chk("scan_255", d, 8'hA5);
    scan_rd(511, d); chk("scan_511", d, 8'hA5);

    // Bus stall at address 100
    key = 8'h3C;
    pulse_go();
    wait_addr("reach_100", 100);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold", {busrq, dma_addr}, {1'b1, 9'd100});
    end
    stall = 1'b0;
    wait_idle("stall_end", 2000);
    errs = 0;
    for (int i = 0; i < 512; i++) begin
      scan_rd(i, d);
      if (d !== img(i, key)) errs++;
    end
    chk("stall_image_errs", errs, 0);

    // Three retriggers during XFER collapse to one extra transfer
    key = 8'h96;
    step();
    clr_mon();
    pulse_go();
    wait_addr("reach_50", 50);
    for (int i = 0; i < 3; i++) begin
      dma_go = 1'b1;
      step();
      dma_go = 1'b0;
      step();
    end
    wait_idle("retrig_end", 3000);
    step();
    step();
    chk("retrig_done_cnt", done_cnt, 2);
    chk("retrig_falls", fall_cnt, 1);
    chk("retrig_rq_cens", rq_cnt, 517 + 514);
    scan_rd(9'h1AB, d); chk("retrig_scan_1ab", d, img(9'h1AB, key));

    // Level held high starts only one transfer
    clr_mon();
    dma_go = 1'b1;
    for (int i = 0; i < 2000; i++) step();
    chk("level_done_cnt", done_cnt, 1);
    chk("level_rq_cens", rq_cnt, 517);
    dma_go = 1'b0;
    step();
    chk("level_idle", {busrq, busy}, 2'b00);

    // Async reset mid-transfer
    key = 8'h21;
    pulse_go();
    wait_addr("reach_300", 300);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {busrq, busy, dma_addr}, '0);
    step();
    step();
    #2 rst_n = 1'b1;
    clr_mon();
    for (int i = 0; i < 20; i++) step();
    chk("post_rst_quiet", {busrq, busy}, 2'b00);
    chk("post_rst_done", done_cnt, 0);
    scan_rd(0, d);   chk("rst_scan_0", d, img(0, 8'h21));
    scan_rd(298, d); chk("rst_scan_298", d, img(298, 8'h21));
    scan_rd(400, d); chk("rst_scan_400_old", d, img(400, 8'h96));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/jtpang_objdma.md
# jtpang_objdma

Object-table DMA engine for the Pang video path. On a CPU DMA trigger it takes the Z80 bus, copies the 512-byte sprite table out of video RAM into a private object RAM, then releases the bus. It sits directly upstream of the object scanner/line-buffer stage.
- It drives the shared VRAM DMA address.
- It owns the bus request.
- It gives the scanner a read port that the CPU cannot disturb mid-frame.

## Interface
Parameters:
- AW, 9: DMA/object RAM address width (table size 2^AW bytes)
- DW, 8: data width

Ports:
- clk  in  1  system clock (48 MHz)
- rst_n  in  1  reset; asynchronous, active-low
- cen  in  1  DMA step enable (pxl_cen); all state advances only on clk edges with cen=1, except reset
- dma_go  in  1  DMA trigger from CPU decode; level sampled on cen, rising edge starts a transfer
- busak_n  in  1  Z80 bus acknowledge, active-low
- busrq  out  1  Z80 bus request, active-high
- dma_addr  out  AW  VRAM read address during transfer
- dma_din  in  DW  VRAM read data; valid one cen after dma_addr
- busy  out  1  high from request until bus release
- done  out  1  one-cen pulse at bus release
- scan_addr  in  AW  object scanner read address
- scan_dout  out  DW  object RAM data; registered, 1 clk latency, independent of cen

## Operation
- Reset values (async, rst_n=0): state IDLE, busrq=0, busy=0, done=0, dma_addr=0, pending=0, scan_dout=0. Object RAM content is undefined; no clear is performed.
- Edge detect: dma_go_l is registered on cen. A start is dma_go & ~dma_go_l.
- IDLE:
  - A start sets busrq=1 and busy=1, goes to REQ, and clears dma_addr to 0.
- REQ:
  - Hold busrq.
  - On cen with busak_n=0, go to XFER.
  - No timeout.
- XFER:
  - Each cen with busak_n=0: dma_addr increments by 1.
  - A one-cen-delayed copy (wr_addr, wr_en) writes dma_din to object RAM[wr_addr].
  - When dma_addr = 2^AW-1 has been issued, go to FLUSH.
  - If busak_n returns high mid-transfer: freeze dma_addr, suppress the pipelined write for that step, and resume when busak_n is low again. No bytes are skipped or duplicated.
- FLUSH:
  - Write the last byte (address 2^AW-1).
  - Drop busrq, drop busy, pulse done; next state IDLE.
- Start while busy: latched in pending and not lost. At FLUSH exit with pending=1, clear pending and go straight to REQ, keeping busrq high with no gap.
- Multiple starts while busy: collapse to a single pending transfer.
- Arithmetic: dma_addr wraps naturally at AW bits. Wrap is never reached inside XFER because FLUSH is taken first.
- Object RAM is a simple dual-port: the write port belongs to DMA, the read port to the scanner.
  - Same-address read and write in one clk returns the old data.
  - Reads are never blocked.

## Timing
- Start latency: dma_go high at cen k, so busrq=1 after cen k.
- First VRAM read: the cen where busak_n=0 is seen in REQ moves to XFER with dma_addr=0 already presented. The first write (addr 0) happens on the following cen.
- Full transfer with busak_n continuously low: 2^AW cens in XFER plus 1 in FLUSH. busrq is high for 2 + 2^AW cens after the start, excluding REQ wait.
- done is high for exactly one cen period, coincident with busrq falling.
- scan_dout updates on every clk edge: value of RAM[scan_addr] sampled on the previous edge.
- Reset asserted mid-transfer: busrq drops immediately (async). Partially copied RAM is left as is. After rst_n rises, no transfer runs until a new dma_go edge.

## Test plan
- Reset/idle:
  - Stimulus: hold rst_n=0, toggle cen; release with dma_go=0.
  - Required: busrq=0, busy=0, done=0, dma_addr=0 throughout; no RAM writes.
- Basic copy:
  - Stimulus: VRAM model byte[i]=i^8'h5A, busak_n low 3 cens after busrq; pulse dma_go.
  - Required: busrq high for 3+2+512 cens; one done pulse; scan reads of addr 0, 255, 511 return 8'h5A, 8'hA5, 8'hA5.
- Bus stall:
  - Stimulus: raise busak_n for 5 cens while dma_addr=100.
  - Required: dma_addr holds at 100; no write during the stall; final RAM equals the VRAM image byte-for-byte.
- Retrigger while busy:
  - Stimulus: three dma_go edges during XFER.
  - Required: exactly one extra transfer; busrq never drops between the two transfers; two done pulses total.
- Level hold:
  - Stimulus: hold dma_go high for 2000 cens.
  - Required: only one transfer.
- Async reset mid-transfer:
  - Stimulus: assert rst_n=0 at dma_addr=300 between clk edges.
  - Required: busrq=0 before the next clk edge; after release, no transfer until a new dma_go edge; scan reads of addresses <299 keep the copied values.
